// File: rtl/fetch_instruction_pkg.sv
// Shared processor definitions: fetch FSM states, HALT opcode, NOP encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_instruction_pkg;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2,
    S_HALT  = 2'd3
  } fetch_state_e;

  localparam logic [4:0]  OP_HALT    = 5'b00000;
  localparam logic [15:0] NOP_INSTR  = 16'h0800;
  localparam logic [15:0] INSTR_STEP = 16'd2;

  // True when the instruction's opcode field marks a HALT.
  function automatic logic is_halt(input logic [15:0] instr);
    return instr[15:11] == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_instruction_pc_register.sv
// 16-bit program counter register with load enable.
// Latency: loaded value visible one clock after ld_i.
// Backpressure: none; holds its value whenever ld_i is low.
module pc_register #(
  parameter logic [15:0] RESET_VAL = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_i,
  input  logic [15:0] d_i,
  output logic [15:0] q_o
);

  logic [15:0] pc_q;

  // Capture the new PC when loaded; async reset to the boot address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_VAL;
    end else if (ld_i) begin
      pc_q <= d_i;
    end
  end

  assign q_o = pc_q;

endmodule

// File: rtl/fetch_instruction.sv
// Instruction fetch stage: one-entry buffer between imem and decode, with redirect/halt.
// Latency: instruction available the cycle after imem_valid; next request after id_ready.
// Backpressure: buffer held while id_ready is low; no new request until drained.
// Optional: define FETCH_PERF_CNT_EN to add the fetch_count performance counter.
module fetch_instruction
  import fetch_instruction_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_en,
  input  logic [15:0] redirect_pc,
  input  logic        id_ready,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_rdata,
  input  logic        imem_valid,
  output logic [15:0] instr_out,
  output logic [15:0] pc_plus2_out,
  output logic        instr_valid,
`ifdef FETCH_PERF_CNT_EN
  output logic [15:0] fetch_count,
`endif
  output logic        halted
);

  fetch_state_e state_q;
  logic [15:0]  req_addr_q;
  logic         imem_req_q;
  logic [15:0]  instr_q;
  logic [15:0]  pc_plus2_q;
  logic         instr_valid_q;
  logic         halted_q;

  logic [15:0]  pc_q;
  logic [15:0]  pc_d;
  logic         pc_ld;
  logic [15:0]  req_plus2;
  logic         fetch_accept;

  // Carry out of bit 15 is dropped, so 16'hFFFE wraps to 16'h0000.
  assign req_plus2    = req_addr_q + INSTR_STEP;
  assign fetch_accept = !redirect_en && (state_q == S_FETCH) && imem_valid;

  // PC follows a redirect, otherwise advances past each accepted fetch.
  always_comb begin
    pc_ld = 1'b0;
    pc_d  = pc_q;
    if (redirect_en) begin
      pc_ld = 1'b1;
      pc_d  = redirect_pc;
    end else if (fetch_accept) begin
      pc_ld = 1'b1;
      pc_d  = req_plus2;
    end
  end

  pc_register #(
    .RESET_VAL (RESET_PC)
  ) u_pc (
    .clk  (clk),
    .rst  (rst),
    .ld_i (pc_ld),
    .d_i  (pc_d),
    .q_o  (pc_q)
  );

  // Fetch FSM with registered outputs; redirect overrides every other event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_FETCH;
      req_addr_q    <= RESET_PC;
      imem_req_q    <= 1'b1;
      instr_q       <= NOP_INSTR;
      pc_plus2_q    <= 16'h0000;
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
    end else if (redirect_en) begin
      instr_valid_q <= 1'b0;
      halted_q      <= 1'b0;
      imem_req_q    <= 1'b1;
      // A request still in flight must be drained at its original address so
      // its response is not mistaken for the redirect target.
      if ((state_q == S_FETCH || state_q == S_DRAIN) && !imem_valid) begin
        state_q <= S_DRAIN;
      end else begin
        state_q    <= S_FETCH;
        req_addr_q <= redirect_pc;
      end
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_valid) begin
            instr_q       <= imem_rdata;
            pc_plus2_q    <= req_plus2;
            instr_valid_q <= 1'b1;
            imem_req_q    <= 1'b0;
            if (is_halt(imem_rdata)) begin
              state_q  <= S_HALT;
              halted_q <= 1'b1;
            end else begin
              state_q <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (id_ready) begin
            instr_valid_q <= 1'b0;
            req_addr_q    <= pc_q;
            imem_req_q    <= 1'b1;
            state_q       <= S_FETCH;
          end
        end
        S_DRAIN: begin
          // Stale response is dropped; restart at the redirected PC.
          if (imem_valid) begin
            req_addr_q <= pc_q;
            state_q    <= S_FETCH;
          end
        end
        S_HALT: begin
          if (id_ready) begin
            instr_valid_q <= 1'b0;
          end
        end
        default: begin
          state_q    <= S_FETCH;
          imem_req_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count_q;

  // Count instructions actually loaded into the buffer; wraps naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q <= 16'h0000;
    end else if (fetch_accept) begin
      fetch_count_q <= fetch_count_q + 16'd1;
    end
  end

  assign fetch_count = fetch_count_q;
`endif

  assign imem_req     = imem_req_q;
  assign imem_addr    = req_addr_q;
  assign instr_out    = instr_q;
  assign pc_plus2_out = pc_plus2_q;
  assign instr_valid  = instr_valid_q;
  assign halted       = halted_q;

endmodule

// File: tb/tb_fetch_instruction.sv
module tb_fetch_instruction;

  logic        clk;
  logic        rst;
  logic        redirect_en;
  logic [15:0] redirect_pc;
  logic        id_ready;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_valid;
  logic [15:0] instr_out;
  logic [15:0] pc_plus2_out;
  logic        instr_valid;
  logic        halted;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
`endif

  fetch_instruction #(.RESET_PC(16'h0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .redirect_en  (redirect_en),
    .redirect_pc  (redirect_pc),
    .id_ready     (id_ready),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_rdata   (imem_rdata),
    .imem_valid   (imem_valid),
    .instr_out    (instr_out),
    .pc_plus2_out (pc_plus2_out),
    .instr_valid  (instr_valid),
`ifdef FETCH_PERF_CNT_EN
    .fetch_count  (fetch_count),
`endif
    .halted       (halted)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic        rd_en;
    logic [15:0] rd_pc;
    logic        id_rdy;
    logic        vld;
    logic [15:0] rdata;
    logic        e_req;
    logic [15:0] e_addr;
    logic        e_ivld;
    logic [15:0] e_instr;
    logic [15:0] e_pp2;
    logic        e_halt;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic rd, input logic [15:0] rpc,
                              input logic idr, input logic v, input logic [15:0] rdat,
                              input logic ereq, input logic [15:0] eaddr, input logic eiv,
                              input logic [15:0] eins, input logic [15:0] epp2, input logic eh);
    vec_t t;
    t.rst = r; t.rd_en = rd; t.rd_pc = rpc; t.id_rdy = idr; t.vld = v; t.rdata = rdat;
    t.e_req = ereq; t.e_addr = eaddr; t.e_ivld = eiv; t.e_instr = eins; t.e_pp2 = epp2;
    t.e_halt = eh;
    return t;
  endfunction

  // Memory contents for the random phase: a fixed scramble of the address.
  logic [15:0] mem_seed;
  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] w;
    w = (a * 16'h9E37) ^ mem_seed;
    return w;
  endfunction

  vec_t vt[25];

  initial begin
    logic        mem_busy;
    logic [15:0] mem_addr;
    int          mem_cnt;
    logic [15:0] exp_pc;
    logic        prev_rd;
    logic        rd;
    logic [15:0] rpc;
    int          n_hs;

    // inputs applied for the next edge | outputs expected before that edge
    //          rst rd  rd_pc     id v  rdata     req addr      iv instr     pp2       h
    vt[0]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0800, 16'h0000, 0);
    vt[1]  = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0000, 0, 16'h0800, 16'h0000, 0);
    vt[2]  = mk(0, 0, 16'h0000, 1, 1, 16'h4000, 1, 16'h0000, 0, 16'h0800, 16'h0000, 0);
    vt[3]  = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h4000, 16'h0002, 0);
    vt[4]  = mk(0, 0, 16'h0000, 0, 1, 16'h4800, 1, 16'h0002, 0, 16'h4000, 16'h0002, 0);
    for (int i = 5; i < 10; i++)
      vt[i] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0002, 1, 16'h4800, 16'h0004, 0);
    vt[10] = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0002, 1, 16'h4800, 16'h0004, 0);
    vt[11] = mk(0, 1, 16'h0100, 0, 0, 16'h0000, 1, 16'h0004, 0, 16'h4800, 16'h0004, 0);
    vt[12] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0004, 0, 16'h4800, 16'h0004, 0);
    vt[13] = mk(0, 0, 16'h0000, 0, 1, 16'h1234, 1, 16'h0004, 0, 16'h4800, 16'h0004, 0);
    vt[14] = mk(0, 0, 16'h0000, 0, 1, 16'h0000, 1, 16'h0100, 0, 16'h4800, 16'h0004, 0);
    vt[15] = mk(0, 0, 16'h0000, 1, 1, 16'h5555, 0, 16'h0100, 1, 16'h0000, 16'h0102, 1);
    vt[16] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 0, 16'h0100, 0, 16'h0000, 16'h0102, 1);
    vt[17] = mk(0, 1, 16'h0040, 0, 0, 16'h0000, 0, 16'h0100, 0, 16'h0000, 16'h0102, 1);
    vt[18] = mk(0, 1, 16'hFFFE, 0, 1, 16'h7777, 1, 16'h0040, 0, 16'h0000, 16'h0102, 0);
    vt[19] = mk(0, 0, 16'h0000, 0, 1, 16'h2222, 1, 16'hFFFE, 0, 16'h0000, 16'h0102, 0);
    vt[20] = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'hFFFE, 1, 16'h2222, 16'h0000, 0);
    vt[21] = mk(0, 0, 16'h0000, 0, 1, 16'h3000, 1, 16'h0000, 0, 16'h2222, 16'h0000, 0);
    vt[22] = mk(0, 0, 16'h0000, 1, 0, 16'h0000, 0, 16'h0000, 1, 16'h3000, 16'h0002, 0);
    vt[23] = mk(0, 1, 16'h0200, 0, 0, 16'h0000, 1, 16'h0002, 0, 16'h3000, 16'h0002, 0);
    vt[24] = mk(0, 0, 16'h0000, 0, 0, 16'h0000, 1, 16'h0002, 0, 16'h3000, 16'h0002, 0);

    rst = 1'b1; redirect_en = 1'b0; redirect_pc = 16'h0000; id_ready = 1'b0;
    imem_valid = 1'b0; imem_rdata = 16'h0000;
    repeat (2) @(posedge clk);

    // Directed table
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      chk($sformatf("v%0d.imem_req", i),     {15'd0, imem_req},    {15'd0, vt[i].e_req});
      chk($sformatf("v%0d.imem_addr", i),    imem_addr,            vt[i].e_addr);
      chk($sformatf("v%0d.instr_valid", i),  {15'd0, instr_valid}, {15'd0, vt[i].e_ivld});
      chk($sformatf("v%0d.instr_out", i),    instr_out,            vt[i].e_instr);
      chk($sformatf("v%0d.pc_plus2_out", i), pc_plus2_out,         vt[i].e_pp2);
      chk($sformatf("v%0d.halted", i),       {15'd0, halted},      {15'd0, vt[i].e_halt});
      rst         = vt[i].rst;
      redirect_en = vt[i].rd_en;
      redirect_pc = vt[i].rd_pc;
      id_ready    = vt[i].id_rdy;
      imem_valid  = vt[i].vld;
      imem_rdata  = vt[i].rdata;
    end

    // Reset asserted while draining: outputs return to reset values without a clock edge.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_drain.instr_valid", {15'd0, instr_valid}, 16'h0000);
    chk("rst_drain.instr_out",   instr_out,            16'h0800);
    chk("rst_drain.imem_addr",   imem_addr,            16'h0000);
    chk("rst_drain.pc_plus2",    pc_plus2_out,         16'h0000);
    chk("rst_drain.imem_req",    {15'd0, imem_req},    16'h0001);
    chk("rst_drain.halted",      {15'd0, halted},      16'h0000);

    // Randomised run against a transaction-level model: every instruction
    // decode accepts must be the next word of the program stream, which
    // restarts at each redirect target.
    mem_seed   = 16'($urandom);
    redirect_en = 1'b0; id_ready = 1'b0; imem_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst      = 1'b0;
    mem_busy = 1'b0;
    mem_addr = 16'h0000;
    mem_cnt  = 0;
    exp_pc   = 16'h0000;
    prev_rd  = 1'b0;
    n_hs     = 0;

    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (prev_rd)
        chk("rnd.halt_clear", {15'd0, halted}, 16'h0000);
      if (mem_busy) begin
        chk("rnd.req_held", {15'd0, imem_req}, 16'h0001);
        chk("rnd.addr_stable", imem_addr, mem_addr);
      end
      if (imem_req)
        chk("rnd.addr_align", {15'd0, imem_addr[0]}, 16'h0000);

      // memory: latches a request, answers 1..3 cycles later with a one-cycle pulse
      imem_valid = 1'b0;
      if (mem_busy) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = mem_word(mem_addr);
          mem_busy   = 1'b0;
        end
      end else if (imem_req) begin
        mem_busy = 1'b1;
        mem_addr = imem_addr;
        mem_cnt  = $urandom_range(1, 3);
      end

      if (halted) rd = ($urandom_range(0, 3) == 0);
      else        rd = ($urandom_range(0, 24) == 0);
      rpc = {16'($urandom) & 16'hFFFE};
      if ($urandom_range(0, 5) == 0) rpc = 16'hFFFE;
      redirect_en = rd;
      redirect_pc = rpc;
      id_ready    = ($urandom_range(0, 2) != 0);

      if (instr_valid && id_ready && !rd) begin
        chk("rnd.instr", instr_out, mem_word(exp_pc));
        chk("rnd.pc_plus2", pc_plus2_out, exp_pc + 16'd2);
        if (instr_out[15:11] == 5'b00000) begin
          chk("rnd.halted", {15'd0, halted}, 16'h0001);
          chk("rnd.halt_noreq", {15'd0, imem_req}, 16'h0000);
        end
        exp_pc = exp_pc + 16'd2;
        n_hs++;
      end
      if (rd) exp_pc = rpc;
      prev_rd = rd;
    end

    n_checks++;
    if (n_hs < 100) begin
      n_fail++;
      $display("FAIL rnd.progress: got %0d accepted instructions expected at least 100", n_hs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
